// File: rtl/hazard_controller_if.sv
// Sequencing-control bundle between ID/EX hazard inputs and pipeline enables.
// slave = controller side, master = pipeline/driver side.
interface hazard_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           idRs;
  logic [4:0]           idRt;
  logic                 idUsesRt;
  logic                 exMemRead;
  logic [4:0]           exRt;
  logic                 branchTaken;
  logic                 mdStart;
  logic                 pcWrite;
  logic                 ifIdWrite;
  logic                 ifIdFlush;
  logic                 idExWrite;
  logic                 idExBubble;
  logic                 exMemBubble;
  logic                 mdBusy;
  logic                 mdDone;
  logic [CNT_WIDTH-1:0] stallCycles;

  modport slave (
    input  idRs, idRt, idUsesRt,
    input  exMemRead, exRt,
    input  branchTaken, mdStart,
    output pcWrite, ifIdWrite, ifIdFlush,
    output idExWrite, idExBubble,
    output exMemBubble, mdBusy, mdDone,
    output stallCycles
  );

  modport master (
    output idRs, idRt, idUsesRt,
    output exMemRead, exRt,
    output branchTaken, mdStart,
    input  pcWrite, ifIdWrite, ifIdFlush,
    input  idExWrite, idExBubble,
    input  exMemBubble, mdBusy, mdDone,
    input  stallCycles
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing: load-use stall, branch flush, multi-cycle MD hold.
// Also counts stalled cycles (pcWrite=0), saturating.
module hazard_controller #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              resetN,
  hazard_controller_if.slave hif
);
  localparam int CW = $clog2(MD_LATENCY);

  typedef enum logic {
    RUN,
    MD_BUSY
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [CW-1:0]        mdCnt;
  logic [CW-1:0]        mdCntNext;
  logic [CNT_WIDTH-1:0] stallCnt;
  logic                 loadUse;

  assign loadUse = hif.exMemRead
    && (hif.exRt != 5'd0)
    && ((hif.exRt == hif.idRs)
      || (hif.idUsesRt && (hif.exRt == hif.idRt)));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= RUN;
      mdCnt <= '0;
    end else begin
      state <= stateNext;
      mdCnt <= mdCntNext;
    end
  end

  always_comb begin
    stateNext       = state;
    mdCntNext       = mdCnt;
    hif.pcWrite     = 1'b1;
    hif.ifIdWrite   = 1'b1;
    hif.ifIdFlush   = 1'b0;
    hif.idExWrite   = 1'b1;
    hif.idExBubble  = 1'b0;
    hif.exMemBubble = 1'b0;
    hif.mdBusy      = 1'b0;
    hif.mdDone      = 1'b0;
    unique case (state)
      RUN: begin
        if (hif.branchTaken) begin
          hif.ifIdFlush  = 1'b1;
          hif.idExBubble = 1'b1;
        end else if (hif.mdStart) begin
          hif.pcWrite     = 1'b0;
          hif.ifIdWrite   = 1'b0;
          hif.idExWrite   = 1'b0;
          hif.exMemBubble = 1'b1;
          stateNext       = MD_BUSY;
          mdCntNext       = CW'(MD_LATENCY - 2);
        end else if (loadUse) begin
          hif.pcWrite    = 1'b0;
          hif.ifIdWrite  = 1'b0;
          hif.idExBubble = 1'b1;
        end
      end
      MD_BUSY: begin
        hif.mdBusy = 1'b1;
        if (mdCnt != '0) begin
          hif.pcWrite     = 1'b0;
          hif.ifIdWrite   = 1'b0;
          hif.idExWrite   = 1'b0;
          hif.exMemBubble = 1'b1;
          mdCntNext       = mdCnt - 1'b1;
        end else begin
          hif.mdDone = 1'b1;
          stateNext  = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stallCnt <= '0;
    end else if (!hif.pcWrite && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign hif.stallCycles = stallCnt;
endmodule

// File: tb/tb_hazard_controller.sv
// Randomized + directed bench for hazard_controller.
// Reference model tracks remaining MD cycles and a saturating stall tally.
module tb_hazard_controller;
  localparam int LAT = 4;
  localparam int W   = 16;
  localparam int MAXC = (1 << W) - 1;

  localparam logic [7:0] O_IDLE  = 8'b1101_0000;
  localparam logic [7:0] O_FLUSH = 8'b1111_1000;
  localparam logic [7:0] O_MDST  = 8'b0000_0100;
  localparam logic [7:0] O_LU    = 8'b0001_1000;
  localparam logic [7:0] O_DONE  = 8'b1101_0011;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_WIDTH(W)) hif ();

  hazard_controller #(
    .MD_LATENCY(LAT),
    .CNT_WIDTH (W)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .hif   (hif)
  );

  int nTests = 0;
  int nFail  = 0;
  int busyLeft = 0;
  int cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic setIn(input int rs, input int rt,
                       input bit uses, input bit mr,
                       input int ert, input bit br,
                       input bit md);
    hif.idRs        = 5'(rs);
    hif.idRt        = 5'(rt);
    hif.idUsesRt    = uses;
    hif.exMemRead   = mr;
    hif.exRt        = 5'(ert);
    hif.branchTaken = br;
    hif.mdStart     = md;
  endtask

  function automatic logic [7:0] expOut();
    bit lu;
    lu = hif.exMemRead && hif.exRt != 0
      && (hif.exRt == hif.idRs
        || (hif.idUsesRt && hif.exRt == hif.idRt));
    if (busyLeft > 1) return 8'b0000_0110;
    if (busyLeft == 1) return O_DONE;
    if (hif.branchTaken) return O_FLUSH;
    if (hif.mdStart) return O_MDST;
    if (lu) return O_LU;
    return O_IDLE;
  endfunction

  function automatic logic [7:0] gotOut();
    return {hif.pcWrite, hif.ifIdWrite, hif.ifIdFlush,
            hif.idExWrite, hif.idExBubble, hif.exMemBubble,
            hif.mdBusy, hif.mdDone};
  endfunction

  task automatic step(input string tag);
    logic [7:0] e;
    #2;
    e = expOut();
    chk({tag, ".outs"}, {24'd0, gotOut()}, {24'd0, e});
    if (!e[7]) cnt = (cnt + 1 > MAXC) ? MAXC : cnt + 1;
    if (busyLeft > 0) busyLeft--;
    else if (!hif.branchTaken && hif.mdStart) busyLeft = LAT - 1;
    @(posedge clk);
    #1;
    chk({tag, ".cnt"}, 32'(hif.stallCycles), 32'(cnt));
  endtask

  task automatic idle();
    setIn(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    resetN = 1'b0;
    idle();
    #12;
    chk("rst.outs", {24'd0, gotOut()}, {24'd0, O_IDLE});
    chk("rst.cnt", 32'(hif.stallCycles), 0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    step("idle");

    setIn(5, 0, 0, 1, 5, 0, 0);
    step("lu");
    idle();
    step("lu.after");
    chk("lu.cnt1", 32'(hif.stallCycles), 1);
    setIn(0, 0, 0, 1, 0, 0, 0);
    step("lu.r0");
    setIn(0, 5, 0, 1, 5, 0, 0);
    step("lu.noRt");
    setIn(0, 5, 1, 1, 5, 0, 0);
    step("lu.rt");

    setIn(5, 0, 0, 1, 5, 1, 0);
    step("br.lu");

    idle();
    hif.mdStart = 1'b1;
    step("md.start");
    hif.mdStart = 1'b0;
    hif.branchTaken = 1'b1;
    step("md.busy1");
    hif.branchTaken = 1'b0;
    step("md.busy2");
    step("md.done");
    step("md.after");

    hif.mdStart = 1'b1;
    step("md2.start");
    idle();
    step("md2.busy");
    resetN = 1'b0;
    busyLeft = 0;
    cnt = 0;
    #2;
    chk("armd.outs", {24'd0, gotOut()}, {24'd0, O_IDLE});
    chk("armd.cnt", 32'(hif.stallCycles), 0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) step("armd.post");

    for (int i = 0; i < 1500; i++) begin
      setIn($urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom), 1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      step("rnd");
    end

    idle();
    repeat (LAT + 1) step("drain");
    setIn(7, 0, 0, 1, 7, 0, 0);
    repeat (70000) @(posedge clk);
    #1;
    cnt = (cnt + 70000 > MAXC) ? MAXC : cnt + 70000;
    chk("sat.cnt", 32'(hif.stallCycles), 32'(cnt));
    chk("sat.ffff", 32'(hif.stallCycles), 32'h0000_FFFF);
    step("sat.hold");
    idle();
    step("sat.end");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
